seq_shifter: RTL and testbench
==============================

// Module: seq_shifter
// PURPOSE
//  Multi-cycle, width-parametrised shift/rotate unit for the datapath ALU.
//  Shifts operand a by 0..WIDTH-1 positions, one position per clock, with a carry-out.
//  Supported modes: LSL, LSR, ASR, ROL, ROR.
//  Sits beside the ALU; the control unit issues start and stalls the PC until done.
//  WIDTH=8 with amt=1 reproduces the legacy single-bit LSL/LSR/ASR results exactly.
// PARAMETERS
//  WIDTH  8                      operand/result width (>=2)
//  AMT_W  $clog2(WIDTH)          shift-amount width (derived; do not override)
// PORTS
//  clk    in   1      system clock, rising edge
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; accepted only when ready=1
//  mode   in   3      000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved
//  amt    in   AMT_W  shift distance
//  a      in   WIDTH  operand
//  ready  out  1      idle, can accept start
//  done   out  1      one-cycle pulse; y/c valid
//  y      out  WIDTH  result, held until the next accepted start
//  c      out  1      last bit shifted/rotated out; 0 when amt=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; ready=1, done=0, y=0, c=0; applies mid-operation too.
//  FSM IDLE->SHIFT->DONE->IDLE:
//   - IDLE: start&ready latches a/mode/amt; amt=0 or reserved mode -> DONE, else SHIFT with cnt=amt.
//   - SHIFT: one shift_step per clk, cnt-1; leaves for DONE when cnt reaches 0.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//  Latency: start accepted at edge k -> done high in cycle k+amt+1 (amt=0: k+1).
//  Handshake: ready=0 in SHIFT and DONE; start ignored there, no queueing.
//   Operands are sampled only at acceptance; later changes on a/amt/mode are ignored.
//  Step rules:
//   - LSL: c<=y[W-1], y<={y[W-2:0],0}
//   - LSR: c<=y[0], y<={0,y[W-1:1]}
//   - ASR: c<=y[0], y<={y[W-1],y[W-1:1]}
//   - ROL: c<=y[W-1], y<={y[W-2:0],y[W-1]}
//   - ROR: c<=y[0], y<={y[0],y[W-1:1]}
//  Accept loads y<=a, c<=0; reserved mode -> y=a, c=0.
//  y is not guaranteed meaningful while ready=0 and done=0.
// CONFIGURATION
//  SEQ_SHIFTER_FLAGS_EN defined: adds outputs z (y==0) and n (y[W-1]).
//   Both are registered with y, reset 0, valid with done.
//  Not defined: ports z/n absent; all other behaviour identical.
// STRUCTURE
//  shifter_pkg:
//   - shift_mode_t enum (3-bit codes above).
//   - shft_state_t enum {IDLE,SHIFT,DONE}.
//   - mode code localparams for the control unit decoder.
//  Sub-module shift_step: combinational one-position shift of {y,c} by mode, WIDTH-parametrised.
//  Top holds the FSM, the down-counter and the y/c registers.
// TESTING (WIDTH=8)
//  LSL a=8'h81 amt=1 -> y=8'h02 c=1, done in cycle k+2 (matches legacy).
//  ASR a=8'hB4 amt=3 -> y=8'hF6 c=1, done in cycle k+4.
//  ROR a=8'h01 amt=1 -> y=8'h80 c=1; LSR a=8'hFF amt=7 -> y=8'h01 c=1, done in cycle k+8.
//  amt=0 a=8'h5A -> y=8'h5A c=0 done at k+1; start pulsed during SHIFT -> ignored, one done only.
//  rst_n low in cycle k+2 of LSL amt=5 -> immediately ready=1 done=0 y=0 c=0; no done later.
//  FLAGS_EN: LSR a=8'h01 amt=1 -> y=0 z=1 n=0 c=1; build without the macro compiles, z/n absent.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and mode codes for the sequential shift/rotate unit.
// Also used by the control-unit decoder, which builds its mode codes from the localparams below.
package shifter_pkg;

    // Mode codes as seen by the control-unit decoder
    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // Operation selector; codes 101-111 are reserved (pass-through)
    typedef enum logic [2:0] {
        SH_LSL = MODE_LSL,
        SH_LSR = MODE_LSR,
        SH_ASR = MODE_ASR,
        SH_ROL = MODE_ROL,
        SH_ROR = MODE_ROR
    } shift_mode_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shft_state_t;

    // True for the reserved codes 101-111
    function automatic logic mode_reserved(input logic [2:0] m);
        return (m > MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-position combinational shift/rotate of {y,c} selected by mode.
// Ports:
//   mode   in  3      operation code (reserved codes hold y/c unchanged)
//   y_in   in  WIDTH  current value
//   c_in   in  1      current carry
//   y_out  out WIDTH  value after one step
//   c_out  out 1      bit shifted/rotated out by this step
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] y_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] y_out,
    output logic             c_out
);

    // Single step per mode
    always_comb begin
        y_out = y_in;
        c_out = c_in;
        case (mode)
            MODE_LSL: begin
                c_out = y_in[WIDTH-1];
                y_out = {y_in[WIDTH-2:0], 1'b0};
            end
            MODE_LSR: begin
                c_out = y_in[0];
                y_out = {1'b0, y_in[WIDTH-1:1]};
            end
            MODE_ASR: begin
                c_out = y_in[0];
                y_out = {y_in[WIDTH-1], y_in[WIDTH-1:1]};
            end
            MODE_ROL: begin
                c_out = y_in[WIDTH-1];
                y_out = {y_in[WIDTH-2:0], y_in[WIDTH-1]};
            end
            MODE_ROR: begin
                c_out = y_in[0];
                y_out = {y_in[0], y_in[WIDTH-1:1]};
            end
            default: begin
                y_out = y_in;
                c_out = c_in;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one position per clock, with carry-out.
// Optional build macro SEQ_SHIFTER_FLAGS_EN adds registered zero (z) and negative (n) flags.
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, accepted only when ready=1
//   mode   in   3      LSL/LSR/ASR/ROL/ROR, 101-111 reserved (pass-through)
//   amt    in   AMT_W  shift distance
//   a      in   WIDTH  operand
//   ready  out  1      idle, can accept start
//   done   out  1      one-cycle pulse, y/c valid
//   y      out  WIDTH  result, held until the next accepted start
//   c      out  1      last bit shifted out (0 when amt=0)
//   z      out  1      y==0            (SEQ_SHIFTER_FLAGS_EN only)
//   n      out  1      y[WIDTH-1]      (SEQ_SHIFTER_FLAGS_EN only)
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] a,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c
`ifdef SEQ_SHIFTER_FLAGS_EN
    ,
    output logic             z,
    output logic             n
`endif
);

    shft_state_t       state_q, state_d;
    logic [AMT_W-1:0]  cnt_q, cnt_d;
    shift_mode_t       mode_q, mode_d;
    logic [WIDTH-1:0]  y_d;
    logic              c_d;
    logic [WIDTH-1:0]  step_y;
    logic              step_c;

    // One-position step of the current result
    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode  (mode_q),
        .y_in  (y),
        .c_in  (c),
        .y_out (step_y),
        .c_out (step_c)
    );

    // Next-state, counter and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        y_d     = y;
        c_d     = c;
        case (state_q)
            IDLE: begin
                if (start) begin
                    y_d    = a;
                    c_d    = 1'b0;
                    mode_d = shift_mode_t'(mode);
                    cnt_d  = amt;
                    if ((amt == '0) || mode_reserved(mode)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                y_d   = step_y;
                c_d   = step_c;
                cnt_d = cnt_q - AMT_W'(1);
                // This step consumes the last position
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= SH_LSL;
            y       <= '0;
            c       <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            y       <= y_d;
            c       <= c_d;
            ready   <= (state_d == IDLE);
            done    <= (state_d == DONE);
        end
    end

`ifdef SEQ_SHIFTER_FLAGS_EN
    // Flags track y so they are valid together with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= 1'b0;
            n <= 1'b0;
        end else begin
            z <= (y_d == '0);
            n <= y_d[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Testbench for seq_shifter (WIDTH=8): directed cases plus randomized operations
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_shifter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'd0;
    logic [AMT_W-1:0] amt = '0;
    logic [WIDTH-1:0] a = '0;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             c;
`ifdef SEQ_SHIFTER_FLAGS_EN
    logic             z;
    logic             n;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seq_shifter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .a     (a),
        .ready (ready),
        .done  (done),
        .y     (y),
        .c     (c)
`ifdef SEQ_SHIFTER_FLAGS_EN
        ,
        .z     (z),
        .n     (n)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {c,y} computed with plain arithmetic on the whole word
    function automatic logic [8:0] ref_model(input logic [2:0] m, input int sh, input logic [7:0] v);
        logic [7:0] r;
        logic       cr;
        if (sh == 0 || m > 3'd4) return {1'b0, v};
        case (m)
            3'd0: begin r = 8'(v << sh);                    cr = v[8-sh]; end
            3'd1: begin r = 8'(v >> sh);                    cr = v[sh-1]; end
            3'd2: begin r = 8'($signed(v) >>> sh);          cr = v[sh-1]; end
            3'd3: begin r = 8'((v << sh) | (v >> (8-sh)));  cr = r[0];    end
            default: begin r = 8'((v >> sh) | (v << (8-sh))); cr = r[7]; end
        endcase
        return {cr, r};
    endfunction

    // Issue one operation and check latency, result and the done pulse.
    // poke_start: pulse start again during SHIFT (must be ignored).
    task automatic run_op(input string tag, input logic [2:0] m, input int sh,
                          input logic [7:0] v, input bit poke_start);
        logic [8:0] exp;
        int         lat;
        int         exp_lat;
        exp     = ref_model(m, sh, v);
        exp_lat = (m > 3'd4) ? 0 : sh;
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(ready), 32'd1);
        mode  = m;
        amt   = AMT_W'(sh);
        a     = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = ~v;
        mode  = 3'($urandom_range(0, 7));
        amt   = AMT_W'($urandom_range(0, 7));
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (poke_start && lat == 1) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_y"}, 32'(y), 32'(exp[7:0]));
        check({tag, "_c"}, 32'(c), 32'(exp[8]));
        check({tag, "_ready_busy"}, 32'(ready), 32'd0);
`ifdef SEQ_SHIFTER_FLAGS_EN
        check({tag, "_z"}, 32'(z), 32'(exp[7:0] == 8'h00));
        check({tag, "_n"}, 32'(n), 32'(exp[7]));
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_y_held"}, 32'(y), 32'(exp[7:0]));
        if (poke_start) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check({tag, "_no_extra_done"}, 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        int         lat;
        // Reset state
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("lsl81", 3'd0, 1, 8'h81, 1'b0);
        run_op("asrB4", 3'd2, 3, 8'hB4, 1'b0);
        run_op("ror01", 3'd4, 1, 8'h01, 1'b0);
        run_op("lsrFF", 3'd1, 7, 8'hFF, 1'b0);
        run_op("amt0", 3'd0, 0, 8'h5A, 1'b0);
        run_op("rol_poke", 3'd3, 5, 8'hC3, 1'b1);
        run_op("lsr01", 3'd1, 1, 8'h01, 1'b0);
        run_op("reserved", 3'd6, 4, 8'h3C, 1'b0);

        // Reset mid-operation: LSL amt=5, rst_n low in cycle k+2
        @(negedge clk);
        mode  = 3'd0;
        amt   = AMT_W'(5);
        a     = 8'hA7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_c", 32'(c), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) lat++;
        end
        check("midrst_no_done", 32'(lat), 32'd0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            v = 8'($urandom);
            run_op("rand", 3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
